// File: rtl/ex_operand_if.sv
// ID-to-EX operand handshake bundle: slot input side and resolved-operand output side.
interface ex_operand_if #(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned FWD_DEPTH = 2
);
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic                 in_rs1_en_i;
    logic                 in_rs2_en_i;
    logic [4:0]           in_rs1_index_i;
    logic [4:0]           in_rs2_index_i;
    logic [XLEN-1:0]      in_rs1_data_i;
    logic [XLEN-1:0]      in_rs2_data_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [XLEN-1:0]      out_rs1_data_o;
    logic [XLEN-1:0]      out_rs2_data_o;
    logic [FWD_DEPTH:0]   out_rs1_src_o;
    logic [FWD_DEPTH:0]   out_rs2_src_o;

    modport slave (
        input  in_valid_i, in_rs1_en_i, in_rs2_en_i, in_rs1_index_i, in_rs2_index_i,
               in_rs1_data_i, in_rs2_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_rs1_data_o, out_rs2_data_o,
               out_rs1_src_o, out_rs2_src_o
    );

    modport master (
        output in_valid_i, in_rs1_en_i, in_rs2_en_i, in_rs1_index_i, in_rs2_index_i,
               in_rs1_data_i, in_rs2_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_rs1_data_o, out_rs2_data_o,
               out_rs1_src_o, out_rs2_src_o
    );
endinterface

// File: rtl/ex_operand_unit.sv
// Single-slot EX operand stage: resolves rs1/rs2 against the forwarding bus and waits out load-use hazards.
// Optional hazard-stall counter enabled by defining EX_OPND_STALL_CNT_EN.
module ex_operand_unit #(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned FWD_DEPTH = 2,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush_i,
    input  logic [FWD_DEPTH-1:0]        fwd_rd_en_i,
    input  logic [FWD_DEPTH-1:0]        fwd_pending_i,
    input  logic [5*FWD_DEPTH-1:0]      fwd_rd_index_i,
    input  logic [XLEN*FWD_DEPTH-1:0]   fwd_rd_data_i,
    output logic [CNT_W-1:0]            stall_cnt_o,
    ex_operand_if.slave                 bus
);
    localparam int unsigned SRC_W = FWD_DEPTH + 1;

    typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_READY} state_e;

    state_e                      state_q, state_d;
    logic [1:0]                  en_q, en_d;
    logic [1:0][4:0]             idx_q, idx_d;
    logic [1:0][XLEN-1:0]        rf_q, rf_d;
    logic [1:0][XLEN-1:0]        data_q, data_d;
    logic [1:0][SRC_W-1:0]       src_q, src_d;
    logic [1:0]                  done_q, done_d;

    logic [1:0]                  sel_en;
    logic [1:0][4:0]             sel_idx;
    logic [1:0][XLEN-1:0]        sel_rf;
    logic [1:0][XLEN-1:0]        res_data;
    logic [1:0][SRC_W-1:0]       res_src;
    logic [1:0]                  res_ok;
    logic                        in_ready_c;
    logic                        accept_c;

    // In WAIT resolve from the captured slot, otherwise from the incoming instruction.
    always_comb begin
        sel_en  = (state_q == S_WAIT) ? en_q  : {bus.in_rs2_en_i, bus.in_rs1_en_i};
        sel_idx = (state_q == S_WAIT) ? idx_q : {bus.in_rs2_index_i, bus.in_rs1_index_i};
        sel_rf  = (state_q == S_WAIT) ? rf_q  : {bus.in_rs2_data_i, bus.in_rs1_data_i};
        res_data = sel_rf;
        res_src  = '0;
        res_ok   = 2'b11;
        for (int o = 0; o < 2; o++) begin
            res_src[o] = SRC_W'(1);
            if (!sel_en[o] || sel_idx[o] == 5'd0) begin
                res_data[o] = '0;
            end else begin
                // Scan oldest to youngest so the youngest matching source wins.
                for (int k = int'(FWD_DEPTH) - 1; k >= 0; k--) begin
                    if (fwd_rd_en_i[k] && fwd_rd_index_i[5*k +: 5] == sel_idx[o]) begin
                        res_data[o] = fwd_rd_data_i[XLEN*k +: XLEN];
                        res_src[o]  = SRC_W'(1) << (k + 1);
                        res_ok[o]   = !fwd_pending_i[k];
                    end
                end
            end
        end
    end

    assign in_ready_c = rst_n && !flush_i &&
                        (state_q == S_EMPTY || (state_q == S_READY && bus.out_ready_i));
    assign accept_c   = bus.in_valid_i && in_ready_c;

    // Slot next-state: load on accept, latch late operands in WAIT, drain on transfer.
    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        idx_d   = idx_q;
        rf_d    = rf_q;
        data_d  = data_q;
        src_d   = src_q;
        done_d  = done_q;
        if (accept_c) begin
            en_d    = sel_en;
            idx_d   = sel_idx;
            rf_d    = sel_rf;
            data_d  = res_data;
            src_d   = res_src;
            done_d  = res_ok;
            state_d = (&res_ok) ? S_READY : S_WAIT;
        end else begin
            case (state_q)
                S_READY: if (bus.out_ready_i) state_d = S_EMPTY;
                S_WAIT: begin
                    for (int o = 0; o < 2; o++) begin
                        if (!done_q[o] && res_ok[o]) begin
                            data_d[o] = res_data[o];
                            src_d[o]  = res_src[o];
                            done_d[o] = 1'b1;
                        end
                    end
                    if (&done_d) state_d = S_READY;
                end
                default: ;
            endcase
        end
        if (flush_i) state_d = S_EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
            en_q    <= '0;
            idx_q   <= '0;
            rf_q    <= '0;
            data_q  <= '0;
            src_q   <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            idx_q   <= idx_d;
            rf_q    <= rf_d;
            data_q  <= data_d;
            src_q   <= src_d;
            done_q  <= done_d;
        end
    end

`ifdef EX_OPND_STALL_CNT_EN
    logic [CNT_W-1:0] stall_q, stall_d;

    // Saturating count of cycles spent waiting on a hazard.
    always_comb begin
        stall_d = stall_q;
        if (state_q == S_WAIT && !flush_i && stall_q != {CNT_W{1'b1}}) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_q <= '0;
        else        stall_q <= stall_d;
    end

    assign stall_cnt_o = stall_q;
`else
    assign stall_cnt_o = '0;
`endif

    assign bus.in_ready_o     = in_ready_c;
    assign bus.out_valid_o    = (state_q == S_READY);
    assign bus.out_rs1_data_o = data_q[0];
    assign bus.out_rs2_data_o = data_q[1];
    assign bus.out_rs1_src_o  = src_q[0];
    assign bus.out_rs2_src_o  = src_q[1];
endmodule
